// File: rtl/shift_collect.sv
//------------------------------------------------------------------------------
// shift_collect
//
// Serial-to-parallel collector. One serial bit is taken per sin handshake and
// WIDTH bits are assembled into a word using the same LR direction rules as
// the parallel-load bidirectional shifter it pairs with. Completed words are
// offered on a valid/ready output port.
//
// Buffering is two words deep: the output register (dout) plus the assembly
// register. When both hold complete words the collector stops accepting bits
// until the consumer drains dout.
//
// Handshake rules (both ports):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   valid must not depend on ready. ready is a function of registered state
//   only, so there is no combinational path from sin_valid to sin_ready or
//   from dout_ready to dout_valid. While dout_valid && !dout_ready, dout and
//   dout_valid hold.
//
// Parameters:
//   WIDTH  word width in bits, 2..32; word ports use [0:WIDTH-1] order
//   CNT_W  bit-counter width, 2**CNT_W > WIDTH
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear, same end state as reset
//   LR           frame direction: 1 = shift toward index 0 (first bit ends at
//                index 0), 0 = shift toward index WIDTH-1 (first bit ends at
//                index WIDTH-1); sampled on the first bit of each frame
//   sin          serial data bit
//   sin_valid    sin is valid this cycle
//   sin_ready    collector can accept a bit this cycle
//   dout         assembled word, [0:WIDTH-1]
//   dout_valid   dout holds an unconsumed word
//   dout_ready   consumer accepts dout this cycle
//   busy         a frame is partially or fully assembled (state != IDLE)
//   o_dbg_state  current FSM state encoding (IDLE=0, COLLECT=1, FULL=2)
//------------------------------------------------------------------------------
module shift_collect #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             LR,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [0:WIDTH-1] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  // Count value held just before the bit that completes a word.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  //----------------------------------------------------------------------------
  // State
  //----------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;        // bits accepted in the current frame
  logic             r_lr;         // direction latched on the frame's first bit
  logic [0:WIDTH-1] r_asm;        // assembly register
  logic [0:WIDTH-1] r_dout;       // output slot
  logic             r_dout_valid;

  //----------------------------------------------------------------------------
  // Combinational helpers
  //----------------------------------------------------------------------------
  logic             w_sin_ready;
  logic             w_accept;
  logic             w_drain;
  logic             w_dir;
  logic             w_last;
  logic [0:WIDTH-1] w_shifted;

  assign w_sin_ready = (r_state != S_FULL);
  assign w_accept    = sin_valid && w_sin_ready;
  assign w_drain     = r_dout_valid && dout_ready;

  // In IDLE the incoming bit is the first of a new frame, so the live LR
  // input decides its direction; afterwards the latched copy is used so that
  // LR changes mid-frame have no effect.
  assign w_dir  = (r_state == S_IDLE) ? LR : r_lr;
  assign w_last = (r_cnt == LAST_CNT);

  // Assembly register with the incoming bit shifted in. With [0:WIDTH-1]
  // ordering the leftmost concatenation element lands at index 0.
  assign w_shifted = w_dir ? {r_asm[1:WIDTH-1], sin}
                           : {sin, r_asm[0:WIDTH-2]};

  //----------------------------------------------------------------------------
  // FSM and datapath
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lr         <= 1'b0;
      r_asm        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (clr) begin
      // Discards the partial frame, any pending word in the assembly
      // register and the word in the output slot; the bit on sin is dropped.
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lr         <= 1'b0;
      r_asm        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_drain) begin
            r_dout_valid <= 1'b0;
          end
          // WIDTH >= 2, so the first bit can never complete a word.
          if (w_accept) begin
            r_asm   <= w_shifted;
            r_lr    <= LR;
            r_cnt   <= CNT_W'(1);
            r_state <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          // Default on a drain is to empty the slot; a word completing in
          // the same cycle overrides this below so there is no bubble.
          if (w_drain) begin
            r_dout_valid <= 1'b0;
          end
          if (w_accept) begin
            r_asm <= w_shifted;
            if (w_last) begin
              r_cnt <= '0;
              if (!r_dout_valid || w_drain) begin
                r_dout       <= w_shifted;
                r_dout_valid <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                // Slot still occupied: keep the finished word in r_asm.
                r_state <= S_FULL;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_FULL: begin
          // dout_valid is necessarily 1 here and stays 1 as the second word
          // moves into the slot.
          if (w_drain) begin
            r_dout  <= r_asm;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // Outputs
  //----------------------------------------------------------------------------
  assign sin_ready   = w_sin_ready;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

  //----------------------------------------------------------------------------
  // Structural invariants
  //----------------------------------------------------------------------------
  // The counter never reaches WIDTH; a completing bit returns it to zero.
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    r_cnt <= LAST_CNT);

  // Between frames the counter is zero.
  a_idle_cnt_zero : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != S_COLLECT) |-> (r_cnt == '0));

  // A held word in the assembly register implies an occupied output slot.
  a_full_has_dout : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_FULL) |-> r_dout_valid);

  // An offered word that is not taken stays put.
  a_dout_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (r_dout_valid && !dout_ready && !clr) |=> (r_dout_valid && $stable(r_dout)));

endmodule
